ram_bus_arbiter: RTL and testbench
==================================

// Module: ram_bus_arbiter
// PURPOSE
// - Shares one single-port ram_memory slave between two bus masters
//   (M0: instruction fetch, M1: load/store) using the rw_address/read/write
//   request-response bus.
// - Sits between the core's two bus ports and the RAM.
// - Grants one master per transaction, registers its command, issues a
//   one-cycle slave request, and routes the slave response back to the winner.
// PARAMETERS
// - FIXED_PRIORITY  0  0: round-robin between M0/M1; 1: M0 always wins a tie
// PORTS
// - clock            in   1   system clock, all state on rising edge
// - reset_n          in   1   asynchronous, active-low reset
// - mN_rw_address    in   32  master N address, N=0,1
// - mN_read_data     out  32  master N read data, valid with mN_read_response
// - mN_read_request  in   1   master N read request, held until response
// - mN_read_response out  1   master N read done, one-cycle pulse
// - mN_write_data    in   32  master N write data
// - mN_write_strobe  in   4   master N byte enables
// - mN_write_request in   1   master N write request, held until response
// - mN_write_response out 1   master N write done, one-cycle pulse
// - s_rw_address     out  32  slave address (registered)
// - s_read_data      in   32  slave read data
// - s_read_request   out  1   slave read request (registered)
// - s_read_response  in   1   slave read done
// - s_write_data     out  32  slave write data (registered)
// - s_write_strobe   out  4   slave byte enables (registered)
// - s_write_request  out  1   slave write request (registered)
// - s_write_response in   1   slave write done
// BEHAVIOUR
// - Master rule: a master holds its request(s) and command fields stable
//   until it sees its response; the next cycle it may drop or issue new.
// - Pending(N) = mN_read_request | mN_write_request.
// - FSM states: IDLE -> ISSUE -> WAIT -> IDLE.
// - IDLE:
//   - If neither master is pending: stay in IDLE, all s_*_request = 0.
//   - Else pick the winner: the sole pending master; if both are pending,
//     FIXED_PRIORITY=1 picks M0, otherwise the master not granted last.
//   - Latch the winner's address, write data, strobe and both request bits
//     into the s_* registers. Go to ISSUE.
// - ISSUE:
//   - s_read_request/s_write_request are high for exactly this one cycle.
//   - Next state is WAIT; all s_* requests are 0 from WAIT onward.
// - WAIT:
//   - Route s_read_data, s_read_response and s_write_response
//     combinationally to the granted master only.
//   - Leave WAIT when every issued request has seen its response
//     (responses arrive together or in any order).
//   - On leaving: record last_grant = winner, go to IDLE.
// - Latency: request seen in cycle T -> slave request in T+1 -> master
//   response in T+2 (RAM latency 1). Back-to-back transactions every
//   3 cycles.
// - Combined read+write from one master: both forwarded in the same
//   transaction; each response is routed independently.
// - Non-granted master: read_data = 32'h0, responses = 0.
// - s_* command registers hold their value between transactions.
// - A request arriving during ISSUE/WAIT waits; it is never dropped.
// - Reset (async, reset_n=0), including mid-transaction:
//   - state = IDLE, last_grant = M1 (so M0 wins the first tie).
//   - All s_* outputs = 0; all m*_response = 0; m*_read_data = 0.
//   - The in-flight transaction is abandoned; the master re-requests.
// TESTING
// - Single M0 read, addr 0x10, slave returns 0xDEADBEEF: s_read_request
//   high in T+1 only; m0_read_response and m0_read_data=0xDEADBEEF in T+2;
//   m1 outputs stay 0.
// - M1 write, addr 0x20, data 0x11223344, strobe 4'b0101: s_write_* carry
//   exactly these values in T+1; m1_write_response pulses in T+2.
// - M0 and M1 both request continuously, round-robin: grants M0, M1, M0, M1
//   with 3-cycle spacing. FIXED_PRIORITY=1: M0 is granted every time while
//   M0 keeps requesting.
// - Combined read+write from M0 with slave responses skewed one cycle apart:
//   FSM stays in WAIT until both arrive; each response is routed in its own
//   cycle.
// - M1 requests while an M0 transaction is in WAIT: M1 is issued in the
//   cycle right after M0 returns to IDLE; no request is lost or duplicated.
// - Assert reset_n=0 during ISSUE: all outputs 0 immediately (async). After
//   release, the still-held request is re-issued and completes normally.

Source files
------------

// File: rtl/ram_bus_arbiter_if.sv
// One rw_address/read/write request-response bus. A master drives the command
// side; the slave (RAM, or the arbiter facing a master) drives the responses.
interface ram_bus_arbiter_if;
   logic [31:0] rw_address;
   logic [31:0] read_data;
   logic        read_request;
   logic        read_response;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        write_request;
   logic        write_response;

   modport master (
      output rw_address, read_request, write_data, write_strobe, write_request,
      input  read_data, read_response, write_response
   );

   modport slave (
      input  rw_address, read_request, write_data, write_strobe, write_request,
      output read_data, read_response, write_response
   );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter in front of a single-port RAM: one granted transaction at a
// time, registered one-cycle slave request, responses routed back to the winner.
module ram_bus_arbiter #(
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   ram_bus_arbiter_if.slave  m0,
   ram_bus_arbiter_if.slave  m1,
   ram_bus_arbiter_if.master s
);
   localparam int NUM_M = 2;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        rd;
      logic        wr;
   } cmd_t;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic              last_q, last_d;
   logic              rd_pend_q, rd_pend_d;
   logic              wr_pend_q, wr_pend_d;
   logic              s_rreq_q, s_rreq_d;
   logic              s_wreq_q, s_wreq_d;
   logic [31:0]       s_addr_q, s_addr_d;
   logic [31:0]       s_wdata_q, s_wdata_d;
   logic [3:0]        s_strb_q, s_strb_d;

   cmd_t [NUM_M-1:0]        mcmd;
   logic [NUM_M-1:0]        pend;
   logic [NUM_M-1:0]        rresp, wresp;
   logic [NUM_M-1:0][31:0]  rdata;
   logic                    winner;

   assign mcmd[0] = '{addr: m0.rw_address, wdata: m0.write_data, strb: m0.write_strobe,
                      rd: m0.read_request, wr: m0.write_request};
   assign mcmd[1] = '{addr: m1.rw_address, wdata: m1.write_data, strb: m1.write_strobe,
                      rd: m1.read_request, wr: m1.write_request};

   for (genvar i = 0; i < NUM_M; i++) begin : g_master
      logic sel;
      assign pend[i]  = mcmd[i].rd | mcmd[i].wr;
      assign sel      = (state_q == WAIT) && (grant_q == 1'(i));
      assign rresp[i] = sel & rd_pend_q & s.read_response;
      assign wresp[i] = sel & wr_pend_q & s.write_response;
      assign rdata[i] = sel ? s.read_data : 32'h0;
   end

   // On a tie, round-robin hands the grant to whoever did not win last time.
   always_comb begin
      if (pend == 2'b11) winner = FIXED_PRIORITY ? 1'b0 : ~last_q;
      else               winner = pend[1] & ~pend[0];
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      rd_pend_d = rd_pend_q;
      wr_pend_d = wr_pend_q;
      s_rreq_d  = 1'b0;
      s_wreq_d  = 1'b0;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_strb_d  = s_strb_q;
      unique case (state_q)
         IDLE: begin
            if (|pend) begin
               grant_d   = winner;
               s_addr_d  = mcmd[winner].addr;
               s_wdata_d = mcmd[winner].wdata;
               s_strb_d  = mcmd[winner].strb;
               s_rreq_d  = mcmd[winner].rd;
               s_wreq_d  = mcmd[winner].wr;
               rd_pend_d = mcmd[winner].rd;
               wr_pend_d = mcmd[winner].wr;
               state_d   = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // Read and write responses may land in either order or together.
            rd_pend_d = rd_pend_q & ~s.read_response;
            wr_pend_d = wr_pend_q & ~s.write_response;
            if (!rd_pend_d && !wr_pend_d) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         rd_pend_q <= 1'b0;
         wr_pend_q <= 1'b0;
         s_rreq_q  <= 1'b0;
         s_wreq_q  <= 1'b0;
         s_addr_q  <= 32'h0;
         s_wdata_q <= 32'h0;
         s_strb_q  <= 4'h0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         rd_pend_q <= rd_pend_d;
         wr_pend_q <= wr_pend_d;
         s_rreq_q  <= s_rreq_d;
         s_wreq_q  <= s_wreq_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_strb_q  <= s_strb_d;
      end
   end

   assign s.rw_address    = s_addr_q;
   assign s.write_data    = s_wdata_q;
   assign s.write_strobe  = s_strb_q;
   assign s.read_request  = s_rreq_q;
   assign s.write_request = s_wreq_q;

   assign m0.read_data      = rdata[0];
   assign m0.read_response  = rresp[0];
   assign m0.write_response = wresp[0];
   assign m1.read_data      = rdata[1];
   assign m1.read_response  = rresp[1];
   assign m1.write_response = wresp[1];
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: directed latency/arbitration/reset cases plus random
// two-master traffic, scored against an ideal word memory and a RAM model.
module tb_ram_bus_arbiter;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   ram_bus_arbiter_if m0_bus(), m1_bus(), s_bus();
   ram_bus_arbiter_if f0_bus(), f1_bus(), fs_bus();

   ram_bus_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
      .clock(clock), .reset_n(reset_n), .m0(m0_bus), .m1(m1_bus), .s(s_bus));
   ram_bus_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
      .clock(clock), .reset_n(reset_n), .m0(f0_bus), .m1(f1_bus), .s(fs_bus));

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Ideal memory (reference) and the RAM model's storage, kept separately.
   logic [31:0] ref_mem [128];
   logic [31:0] slv_mem [128];
   logic [31:0] exp_rd0[$], exp_rd1[$];
   int          exp_wr [2] = '{0, 0};

   bit          act [2] = '{0, 0};
   bit          cur_rd [2], cur_wr [2];
   logic [31:0] cur_a [2], cur_d [2];
   logic [3:0]  cur_s [2];
   int txn_id [2] = '{0, 0};
   int iss_id [2] = '{-1, -1};
   int req_cyc [2], iss_cyc [2], rd_cyc [2], wr_cyc [2];
   int rd_lat = 1, wr_lat = 1;
   bit rnd_lat = 0;
   int glog[$], gcyc[$];
   int fp_iss0 = 0, fp_iss1 = 0;

   function automatic logic [31:0] init_word(input int i);
      return (i == 4) ? 32'hDEADBEEF : (32'h5A00_0000 | 32'(i * 131));
   endfunction

   function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endfunction

   function automatic bit rresp(input int n);
      return (n == 0) ? m0_bus.read_response : m1_bus.read_response;
   endfunction
   function automatic bit wresp(input int n);
      return (n == 0) ? m0_bus.write_response : m1_bus.write_response;
   endfunction
   function automatic logic [31:0] rdat(input int n);
      return (n == 0) ? m0_bus.read_data : m1_bus.read_data;
   endfunction

   task automatic drive(input int n, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st);
      if (n == 0) begin
         m0_bus.read_request = rd; m0_bus.write_request = wr; m0_bus.rw_address = a;
         m0_bus.write_data = d; m0_bus.write_strobe = st;
      end else begin
         m1_bus.read_request = rd; m1_bus.write_request = wr; m1_bus.rw_address = a;
         m1_bus.write_data = d; m1_bus.write_strobe = st;
      end
   endtask

   task automatic m_drop(input int n);
      @(negedge clock);
      drive(n, 0, 0, 32'h0, 32'h0, 4'h0);
   endtask

   // Present one transaction, record expectations, hold until all responses seen.
   task automatic m_txn(input int n, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st);
      bit rd_seen, wr_seen;
      int t;
      @(negedge clock);
      cur_rd[n] = rd; cur_wr[n] = wr; cur_a[n] = a; cur_d[n] = d; cur_s[n] = st;
      txn_id[n]++;
      act[n] = 1'b1;
      drive(n, rd, wr, a, d, st);
      req_cyc[n] = cyc;
      if (rd) begin
         if (n == 0) exp_rd0.push_back(ref_mem[a[8:2]]);
         else        exp_rd1.push_back(ref_mem[a[8:2]]);
      end
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (st[b]) ref_mem[a[8:2]][8*b +: 8] = d[8*b +: 8];
         exp_wr[n]++;
      end
      rd_seen = !rd; wr_seen = !wr; t = 0;
      while (!(rd_seen && wr_seen) && t < 60) begin
         @(negedge clock);
         t++;
         if (rresp(n) && !rd_seen) begin rd_seen = 1'b1; rd_cyc[n] = cyc; end
         if (wresp(n) && !wr_seen) begin wr_seen = 1'b1; wr_cyc[n] = cyc; end
      end
      chk($sformatf("m%0d_txn_done_in_time", n), 32'(rd_seen && wr_seen), 1);
      act[n] = 1'b0;
   endtask

   task automatic rand_txn(input int n);
      int sel, gap;
      logic [31:0] a;
      sel = $urandom_range(2, 0);
      gap = $urandom_range(3, 0);
      a = 32'(n * 256 + 4 * $urandom_range(63, 0));
      if (gap > 0) begin
         m_drop(n);
         repeat (gap - 1) @(negedge clock);
      end
      m_txn(n, sel != 1, sel != 0, a, $urandom, 4'($urandom_range(15, 1)));
   endtask

   task automatic monitor(input int n);
      forever begin
         @(negedge clock);
         if (rresp(n)) begin
            chk($sformatf("m%0d_rd_expected", n),
                32'(((n == 0) ? exp_rd0.size() : exp_rd1.size()) != 0), 1);
            if (n == 0 && exp_rd0.size() != 0) chk("m0_rdata", rdat(0), exp_rd0.pop_front());
            if (n == 1 && exp_rd1.size() != 0) chk("m1_rdata", rdat(1), exp_rd1.pop_front());
         end else begin
            chk($sformatf("m%0d_rdata_idle", n), rdat(n), 0);
         end
         if (wresp(n)) begin
            chk($sformatf("m%0d_wr_expected", n), 32'(exp_wr[n] != 0), 1);
            if (exp_wr[n] != 0) exp_wr[n]--;
         end
      end
   endtask

   initial begin
      fork
         monitor(0);
         monitor(1);
      join_none
   end

   // RAM model: checks each issued command against the owning master, answers later.
   initial begin
      int rc, wc, own;
      bit prev_req;
      logic [31:0] rhold;
      rc = 0; wc = 0; prev_req = 1'b0; rhold = 32'h0;
      for (int i = 0; i < 128; i++) slv_mem[i] = init_word(i);
      s_bus.read_data = 32'h0; s_bus.read_response = 1'b0; s_bus.write_response = 1'b0;
      forever begin
         @(posedge clock); #1;
         s_bus.read_data = 32'h0; s_bus.read_response = 1'b0; s_bus.write_response = 1'b0;
         if (!reset_n) begin
            rc = 0; wc = 0; prev_req = 1'b0;
            iss_id[0] = -1; iss_id[1] = -1;
         end else begin
            if (rc > 0) begin
               rc--;
               if (rc == 0) begin s_bus.read_response = 1'b1; s_bus.read_data = rhold; end
            end
            if (wc > 0) begin
               wc--;
               if (wc == 0) s_bus.write_response = 1'b1;
            end
            if (s_bus.read_request || s_bus.write_request) begin
               own = (act[0] && act[1]) ? int'(s_bus.rw_address[8]) : int'(act[1]);
               chk("s_req_single_cycle", 32'(prev_req), 0);
               chk("s_issue_has_owner", 32'(act[0] || act[1]), 1);
               chk("s_addr", s_bus.rw_address, cur_a[own]);
               chk("s_rd_req", 32'(s_bus.read_request), 32'(cur_rd[own]));
               chk("s_wr_req", 32'(s_bus.write_request), 32'(cur_wr[own]));
               if (cur_wr[own]) begin
                  chk("s_wdata", s_bus.write_data, cur_d[own]);
                  chk("s_strobe", 32'(s_bus.write_strobe), 32'(cur_s[own]));
               end
               chk("s_not_duplicated", 32'(iss_id[own] != txn_id[own]), 1);
               iss_id[own] = txn_id[own];
               iss_cyc[own] = cyc;
               glog.push_back(own);
               gcyc.push_back(cyc);
               if (s_bus.read_request) begin
                  rhold = slv_mem[s_bus.rw_address[8:2]];
                  rc = rnd_lat ? int'($urandom_range(3, 1)) : rd_lat;
               end
               if (s_bus.write_request) begin
                  for (int b = 0; b < 4; b++)
                     if (s_bus.write_strobe[b])
                        slv_mem[s_bus.rw_address[8:2]][8*b +: 8] = s_bus.write_data[8*b +: 8];
                  wc = rnd_lat ? int'($urandom_range(3, 1)) : wr_lat;
               end
            end
            prev_req = s_bus.read_request || s_bus.write_request;
         end
      end
   end

   // Fixed-priority instance: both masters read continuously, M0 must always win.
   initial begin
      bit fp_prev;
      fp_prev = 1'b0;
      f0_bus.rw_address = 32'h004; f0_bus.read_request = 1'b1; f0_bus.write_request = 1'b0;
      f0_bus.write_data = 32'h0;   f0_bus.write_strobe = 4'h0;
      f1_bus.rw_address = 32'h104; f1_bus.read_request = 1'b1; f1_bus.write_request = 1'b0;
      f1_bus.write_data = 32'h0;   f1_bus.write_strobe = 4'h0;
      fs_bus.read_data = 32'h0; fs_bus.read_response = 1'b0; fs_bus.write_response = 1'b0;
      forever begin
         @(posedge clock); #1;
         fs_bus.read_response = fp_prev & reset_n;
         fs_bus.read_data = fs_bus.read_response ? 32'h55 : 32'h0;
         fp_prev = fs_bus.read_request & reset_n;
         if (fs_bus.read_request) begin
            if (fs_bus.rw_address[8]) fp_iss1++;
            else                      fp_iss0++;
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_rreq"}, 32'(s_bus.read_request), 0);
      chk({tag, "_s_wreq"}, 32'(s_bus.write_request), 0);
      chk({tag, "_s_addr"}, s_bus.rw_address, 0);
      chk({tag, "_s_wdata"}, s_bus.write_data, 0);
      chk({tag, "_s_strobe"}, 32'(s_bus.write_strobe), 0);
      chk({tag, "_m0_rresp"}, 32'(m0_bus.read_response), 0);
      chk({tag, "_m0_rdata"}, m0_bus.read_data, 0);
      chk({tag, "_m1_wresp"}, 32'(m1_bus.write_response), 0);
   endtask

   initial begin
      drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
      drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      reset_n = 1'b1;

      // Single M0 read of 0xDEADBEEF at 0x10.
      m_txn(0, 1, 0, 32'h10, 32'h0, 4'h0);
      m_drop(0);
      chk("m0_read_issue_latency", 32'(iss_cyc[0] - req_cyc[0]), 1);
      chk("m0_read_resp_latency", 32'(rd_cyc[0] - req_cyc[0]), 2);

      // M1 write; command registers must hold afterwards.
      m_txn(1, 0, 1, 32'h20, 32'h11223344, 4'b0101);
      m_drop(1);
      chk("m1_write_issue_latency", 32'(iss_cyc[1] - req_cyc[1]), 1);
      chk("m1_write_resp_latency", 32'(wr_cyc[1] - req_cyc[1]), 2);
      repeat (2) @(negedge clock);
      chk("s_addr_held", s_bus.rw_address, 32'h20);
      chk("s_wdata_held", s_bus.write_data, 32'h11223344);
      chk("s_strobe_held", 32'(s_bus.write_strobe), 32'h5);
      chk("s_req_idle", 32'(s_bus.read_request | s_bus.write_request), 0);

      // Both masters request back-to-back: grants alternate every 3 cycles.
      glog.delete(); gcyc.delete();
      fork
         begin
            for (int k = 0; k < 2; k++) m_txn(0, 1, 0, 32'(32'h40 + 4 * k), 32'h0, 4'h0);
            m_drop(0);
         end
         begin
            for (int k = 0; k < 2; k++) m_txn(1, 1, 0, 32'(32'h140 + 4 * k), 32'h0, 4'h0);
            m_drop(1);
         end
      join
      chk("rr_grant_count", 32'(glog.size()), 4);
      for (int k = 0; k < glog.size(); k++) begin
         chk($sformatf("rr_grant_%0d", k), 32'(glog[k]), 32'(k % 2));
         if (k > 0) chk($sformatf("rr_spacing_%0d", k), 32'(gcyc[k] - gcyc[k-1]), 3);
      end

      // Combined M0 read+write with skewed responses; M1 arrives during M0's WAIT.
      rd_lat = 1; wr_lat = 2;
      fork
         begin m_txn(0, 1, 1, 32'h80, 32'hCAFEF00D, 4'hF); m_drop(0); end
         begin repeat (2) @(negedge clock); m_txn(1, 1, 0, 32'h180, 32'h0, 4'h0); m_drop(1); end
      join
      chk("cw_rd_resp_cycle", 32'(rd_cyc[0] - iss_cyc[0]), 1);
      chk("cw_wr_resp_cycle", 32'(wr_cyc[0] - iss_cyc[0]), 2);
      chk("m1_issued_after_m0_idle", 32'(iss_cyc[1] - wr_cyc[0]), 2);
      rd_lat = 1; wr_lat = 1;

      // Reset during ISSUE: outputs clear at once, held request is re-issued.
      fork
         begin m_txn(0, 1, 0, 32'hC0, 32'h0, 4'h0); m_drop(0); end
         begin
            int t;
            t = 0;
            while (!s_bus.read_request && t < 20) begin @(posedge clock); #1; t++; end
            chk("rst_issue_seen", 32'(s_bus.read_request), 1);
            #2 reset_n = 1'b0;
            #1 chk_all_zero("async_reset");
            @(posedge clock);
            @(negedge clock);
            reset_n = 1'b1;
         end
      join

      // Random two-master traffic with random RAM latencies.
      rnd_lat = 1;
      fork
         begin for (int k = 0; k < 60; k++) rand_txn(0); m_drop(0); end
         begin for (int k = 0; k < 60; k++) rand_txn(1); m_drop(1); end
      join
      repeat (6) @(negedge clock);
      chk("sb_m0_rd_drained", 32'(exp_rd0.size()), 0);
      chk("sb_m1_rd_drained", 32'(exp_rd1.size()), 0);
      chk("sb_m0_wr_drained", 32'(exp_wr[0]), 0);
      chk("sb_m1_wr_drained", 32'(exp_wr[1]), 0);

      chk("fp_m1_never_granted", 32'(fp_iss1), 0);
      chk("fp_m0_granted_repeatedly", 32'(fp_iss0 >= 10), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
